// File: rtl/store_buffer_if.sv
// Pipeline-side bundle of the store buffer: store requests, load requests,
// fence control and the data_memory port driven by the buffer.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic [2:0]    st_type;
    logic          st_ready;

    logic          ld_req;
    logic [31:0]   ld_addr;
    logic [2:0]    ld_type;
    logic          ld_stall;

    logic          fence;
    logic          fence_busy;
    logic [CW-1:0] count;

    logic          store;
    logic [31:0]   direccion;
    logic [31:0]   store_data;
    logic [31:0]   offset;
    logic [2:0]    Type;

    modport master (
        output st_valid, st_addr, st_data, st_type, ld_req, ld_addr, ld_type, fence,
        input  st_ready, ld_stall, fence_busy, count,
               store, direccion, store_data, offset, Type
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_type, ld_req, ld_addr, ld_type, fence,
        output st_ready, ld_stall, fence_busy, count,
               store, direccion, store_data, offset, Type
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and data_memory: loads take the
// memory port unless they overlap a pending store, otherwise the head drains.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  typ;
    } entry_t;

    typedef enum logic [1:0] {
        SEL_IDLE,
        SEL_LOAD,
        SEL_DRAIN
    } port_sel_e;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          fence_pending_q;
    logic          fence_pending_d;

    logic          st_ready;
    logic          push;
    logic          pop;
    logic          entry_hit;
    logic          hazard;
    port_sel_e     sel;
    entry_t        head;

    // Readiness depends only on registered state so a full buffer never
    // accepts a store on the same edge its head retires.
    assign st_ready = (count_q < CW'(DEPTH)) && !fence_pending_q;
    assign push     = bus.st_valid && st_ready;
    assign head     = mem[rd_ptr_q];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        entry_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CW'(k) < count_q) &&
                (mem[rd_ptr_q + AW'(k)].addr[31:2] == bus.ld_addr[31:2])) begin
                entry_hit = 1'b1;
            end
        end
    end

    assign hazard = bus.ld_req &&
                    (entry_hit || (push && (bus.st_addr[31:2] == bus.ld_addr[31:2])));

    // A non-conflicting load owns the port; otherwise the head store drains,
    // which also guarantees a stalled load eventually sees its store retire.
    always_comb begin
        sel = SEL_IDLE;
        if (bus.ld_req && !hazard) begin
            sel = SEL_LOAD;
        end else if (count_q != '0) begin
            sel = SEL_DRAIN;
        end
    end

    assign pop = (sel == SEL_DRAIN);

    always_comb begin
        bus.store      = 1'b0;
        bus.direccion  = '0;
        bus.store_data = '0;
        bus.Type       = '0;
        unique case (sel)
            SEL_LOAD: begin
                bus.direccion = bus.ld_addr;
                bus.Type      = bus.ld_type;
            end
            SEL_DRAIN: begin
                bus.store      = 1'b1;
                bus.direccion  = head.addr;
                bus.store_data = head.data;
                bus.Type       = head.typ;
            end
            default: ;
        endcase
    end

    assign count_d         = count_q + CW'(push) - CW'(pop);
    assign fence_pending_d = (fence_pending_q || bus.fence) && (count_d != '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            fence_pending_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q         <= count_d;
            fence_pending_q <= fence_pending_d;
        end
    end

    // NOTE: entry storage has no reset; an entry is only ever read while count
    // marks it occupied, and clearing count on reset discards all of them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{addr: bus.st_addr, data: bus.st_data, typ: bus.st_type};
        end
    end

    assign bus.st_ready   = st_ready;
    assign bus.ld_stall   = hazard;
    assign bus.fence_busy = fence_pending_q && (count_q != '0);
    assign bus.count      = count_q;
    assign bus.offset     = '0;
endmodule
